// File: rtl/rx_pkt_fifo.sv
// rx_pkt_fifo
//   Receive-side packet buffer for the GEMAC RX client interface. Frame bytes
//   are written into a circular data RAM; a frame becomes visible to the
//   reader only when the MAC ends it good, the frame is non-empty and
//   did not overflow, and a length slot is free. Anything else rewinds the
//   write pointer so the frame vanishes. Committed frames are replayed as a
//   valid/ready byte stream with start/end-of-frame markers.
//
// Ports
//   clk          sole clock (MAC rx_clk)
//   reset_n      asynchronous active-low reset
//   rx_data      frame byte from the MAC
//   rx_valid     rx_data valid this cycle
//   rx_error     1-cycle strobe: current frame ended bad
//   rx_ack       1-cycle strobe: current frame ended good
//   out_data     output byte
//   out_sof      first byte of a frame (qualified by out_valid)
//   out_eof      last byte of a frame (qualified by out_valid)
//   out_valid    output beat available
//   out_ready    consumer accepts the beat
//   drop_count   dropped frames, wraps
//   frame_count  committed frames, wraps
module rx_pkt_fifo #(
  parameter int AWIDTH = 11,
  parameter int LWIDTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_error,
  input  logic        rx_ack,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] drop_count,
  output logic [15:0] frame_count
);

  localparam int DEPTH  = 1 << AWIDTH;
  localparam int LDEPTH = 1 << LWIDTH;
  localparam logic [AWIDTH-1:0] AONE = {{(AWIDTH-1){1'b0}}, 1'b1};
  localparam logic [LWIDTH-1:0] LONE = {{(LWIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND} rd_state_e;

  logic [7:0]  mem    [DEPTH];
  logic [15:0] lf_mem [LDEPTH];

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d, ram_rd_addr;
  logic [15:0]       len_q, len_d, rcnt_q, rcnt_d;
  logic [15:0]       drop_q, drop_d, frame_q, frame_d;
  logic              ovf_q, ovf_d, first_q, first_d;
  logic [LWIDTH-1:0] lf_wr_q, lf_wr_d, lf_rd_q, lf_rd_d, lf_rd_next;
  logic [7:0]        rd_data_q, rd_data_d;
  rd_state_e         state_q, state_d;

  logic ram_full, wr_en, lf_full, lf_empty, lf_push, ram_rd_en;

  // rd_ptr_q is the byte currently presented, so it is still occupied;
  // this keeps the full test conservative by one byte when a read and a
  // write land in the same cycle.
  assign ram_full   = (wr_ptr_q + AONE) == rd_ptr_q;
  assign lf_full    = (lf_wr_q + LONE) == lf_rd_q;
  assign lf_empty   = lf_wr_q == lf_rd_q;
  assign lf_rd_next = lf_rd_q + LONE;

  // Write side: byte capture, overflow tracking and commit/drop decision.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    drop_d       = drop_q;
    frame_d      = frame_q;
    lf_wr_d      = lf_wr_q;
    lf_push      = 1'b0;
    wr_en        = 1'b0;
    if (rx_error) begin
      wr_ptr_d = commit_ptr_q;
      drop_d   = drop_q + 16'd1;
      len_d    = 16'd0;
      ovf_d    = 1'b0;
    end else if (rx_ack) begin
      if (!ovf_q && (len_q != 16'd0) && !lf_full) begin
        lf_push      = 1'b1;
        lf_wr_d      = lf_wr_q + LONE;
        commit_ptr_d = wr_ptr_q;
        frame_d      = frame_q + 16'd1;
      end else begin
        wr_ptr_d = commit_ptr_q;
        drop_d   = drop_q + 16'd1;
      end
      len_d = 16'd0;
      ovf_d = 1'b0;
    end else if (rx_valid && !ovf_q) begin
      if (ram_full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AONE;
        len_d    = len_q + 16'd1;
      end
    end
  end

  // Read side. The head length slot is only retired once the frame's last
  // byte is accepted, so a frame being streamed still counts as pending
  // against the length FIFO capacity.
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    rcnt_d      = rcnt_q;
    first_d     = first_q;
    lf_rd_d     = lf_rd_q;
    ram_rd_en   = 1'b0;
    ram_rd_addr = rd_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!lf_empty) begin
          rcnt_d  = lf_mem[lf_rd_q];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ram_rd_en = 1'b1;
        first_d   = 1'b1;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + AONE;
          rcnt_d   = rcnt_q - 16'd1;
          first_d  = 1'b0;
          if (rcnt_q == 16'd1) begin
            lf_rd_d = lf_rd_next;
            if (lf_rd_next != lf_wr_q) begin
              rcnt_d  = lf_mem[lf_rd_next];
              state_d = ST_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            ram_rd_en   = 1'b1;
            ram_rd_addr = rd_ptr_q + AONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data register only loads on a read, so a stalled beat holds.
  assign rd_data_d = ram_rd_en ? mem[ram_rd_addr] : rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en)   mem[wr_ptr_q]   <= rx_data;
    if (lf_push) lf_mem[lf_wr_q] <= len_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      rcnt_q       <= '0;
      ovf_q        <= 1'b0;
      first_q      <= 1'b0;
      drop_q       <= '0;
      frame_q      <= '0;
      lf_wr_q      <= '0;
      lf_rd_q      <= '0;
      rd_data_q    <= '0;
      state_q      <= ST_IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      len_q        <= len_d;
      rcnt_q       <= rcnt_d;
      ovf_q        <= ovf_d;
      first_q      <= first_d;
      drop_q       <= drop_d;
      frame_q      <= frame_d;
      lf_wr_q      <= lf_wr_d;
      lf_rd_q      <= lf_rd_d;
      rd_data_q    <= rd_data_d;
      state_q      <= state_d;
    end
  end

  assign out_valid   = state_q == ST_SEND;
  assign out_sof     = (state_q == ST_SEND) && first_q;
  assign out_eof     = (state_q == ST_SEND) && (rcnt_q == 16'd1);
  assign out_data    = rd_data_q;
  assign drop_count  = drop_q;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_rx_pkt_fifo.sv
// tb_rx_pkt_fifo
//   Bench for rx_pkt_fifo. Two instances share one stimulus bus: the main one
//   with default sizes and a small one (AWIDTH=6) for the overflow scenario;
//   use_small routes stimulus and selects which outputs are observed.
module tb_rx_pkt_fifo;

  localparam int LCAP = 15;

  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [7:0]  stim_data;
  logic        stim_valid, stim_error, stim_ack, stim_ready;
  logic        use_small;

  logic [7:0]  m_out_data, s_out_data;
  logic        m_out_sof, m_out_eof, m_out_valid;
  logic        s_out_sof, s_out_eof, s_out_valid;
  logic [15:0] m_drop, m_frame, s_drop, s_frame;

  rx_pkt_fifo dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(stim_data),
    .rx_valid(stim_valid & ~use_small),
    .rx_error(stim_error & ~use_small),
    .rx_ack(stim_ack & ~use_small),
    .out_data(m_out_data), .out_sof(m_out_sof), .out_eof(m_out_eof),
    .out_valid(m_out_valid),
    .out_ready(stim_ready & ~use_small),
    .drop_count(m_drop), .frame_count(m_frame)
  );

  rx_pkt_fifo #(.AWIDTH(6), .LWIDTH(4)) dut_small (
    .clk(clk), .reset_n(reset_n),
    .rx_data(stim_data),
    .rx_valid(stim_valid & use_small),
    .rx_error(stim_error & use_small),
    .rx_ack(stim_ack & use_small),
    .out_data(s_out_data), .out_sof(s_out_sof), .out_eof(s_out_eof),
    .out_valid(s_out_valid),
    .out_ready(stim_ready & use_small),
    .drop_count(s_drop), .frame_count(s_frame)
  );

  logic [7:0]  mon_data;
  logic        mon_sof, mon_eof, mon_valid;
  logic [15:0] mon_drop, mon_frame;
  assign mon_data  = use_small ? s_out_data  : m_out_data;
  assign mon_sof   = use_small ? s_out_sof   : m_out_sof;
  assign mon_eof   = use_small ? s_out_eof   : m_out_eof;
  assign mon_valid = use_small ? s_out_valid : m_out_valid;
  assign mon_drop  = use_small ? s_drop      : m_drop;
  assign mon_frame = use_small ? s_frame     : m_frame;

  // Reference model: committed bytes awaiting delivery, the frame being
  // received, and frame/drop bookkeeping.
  byte_t exp_data[$];
  bit    exp_sof[$];
  bit    exp_eof[$];
  byte_t cur_frame[$];
  bit    cur_ovf;
  int    pending, exp_frames, exp_drops, model_depth;
  int    sof_seen, eof_seen, beats_seen;
  int    ready_mode;
  int    tests_run = 0;
  int    failures  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_mode == 2) stim_ready = 1'($urandom_range(0, 1));
    else                 stim_ready = (ready_mode == 1);
  endtask

  task automatic setReady(input int mode);
    ready_mode = mode;
    if (mode == 2) stim_ready = 1'($urandom_range(0, 1));
    else           stim_ready = (mode == 1);
  endtask

  task automatic clearModel();
    exp_data.delete();
    exp_sof.delete();
    exp_eof.delete();
    cur_frame.delete();
    cur_ovf    = 1'b0;
    pending    = 0;
    exp_frames = 0;
    exp_drops  = 0;
    sof_seen   = 0;
    eof_seen   = 0;
    beats_seen = 0;
  endtask

  // One input cycle; the model decides acceptance/commit from what has been
  // delivered before the edge that samples this cycle.
  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic err, input logic ack);
    stim_valid = v;
    stim_data  = d;
    stim_error = err;
    stim_ack   = ack;
    if (v) begin
      if (!cur_ovf) begin
        if (exp_data.size() + cur_frame.size() < model_depth - 1) cur_frame.push_back(d);
        else cur_ovf = 1'b1;
      end
    end else if (err) begin
      exp_drops++;
      cur_frame.delete();
      cur_ovf = 1'b0;
    end else if (ack) begin
      if (!cur_ovf && cur_frame.size() != 0 && pending < LCAP) begin
        for (int i = 0; i < cur_frame.size(); i++) begin
          exp_data.push_back(cur_frame[i]);
          exp_sof.push_back(i == 0);
          exp_eof.push_back(i == cur_frame.size() - 1);
        end
        pending++;
        exp_frames++;
      end else begin
        exp_drops++;
      end
      cur_frame.delete();
      cur_ovf = 1'b0;
    end
    tick();
    stim_valid = 1'b0;
    stim_error = 1'b0;
    stim_ack   = 1'b0;
  endtask

  task automatic sendFrame(input int len, input bit ramp, input bit bad);
    for (int i = 0; i < len; i++)
      applyStimulus(1'b1, ramp ? 8'(i) : 8'($urandom), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, bad, ~bad);
  endtask

  task automatic drainOutput(input int max_cycles);
    int n = 0;
    while (exp_data.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    checkOutput("drain_done", exp_data.size(), 0);
    repeat (3) tick();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, mon_valid, 0);
    checkOutput({tag, "_sof"},   mon_sof,   0);
    checkOutput({tag, "_eof"},   mon_eof,   0);
    checkOutput({tag, "_data"},  mon_data,  0);
    checkOutput({tag, "_drop"},  mon_drop,  0);
    checkOutput({tag, "_frame"}, mon_frame, 0);
  endtask

  task automatic doReset();
    reset_n    = 1'b0;
    stim_valid = 1'b0;
    stim_error = 1'b0;
    stim_ack   = 1'b0;
    stim_data  = 8'h00;
    repeat (2) tick();
    checkResetOutputs("rst");
    clearModel();
    reset_n = 1'b1;
    tick();
  endtask

  // Output monitor: every presented beat is compared with the head of the
  // expected stream; a stalled beat must keep matching the same head entry.
  always @(negedge clk) begin
    if (reset_n && mon_valid) begin
      checkOutput("beat_expected", exp_data.size() != 0, 1);
      if (exp_data.size() != 0) begin
        checkOutput("out_data", mon_data, exp_data[0]);
        checkOutput("out_sof",  mon_sof,  exp_sof[0]);
        checkOutput("out_eof",  mon_eof,  exp_eof[0]);
        if (stim_ready) begin
          if (mon_sof) sof_seen++;
          if (mon_eof) eof_seen++;
          beats_seen++;
          if (exp_eof[0]) pending--;
          void'(exp_data.pop_front());
          void'(exp_sof.pop_front());
          void'(exp_eof.pop_front());
        end
      end
    end
  end

  initial begin
    int lat;
    int len;
    int kind;
    reset_n     = 1'b0;
    use_small   = 1'b0;
    stim_valid  = 1'b0;
    stim_error  = 1'b0;
    stim_ack    = 1'b0;
    stim_data   = 8'h00;
    stim_ready  = 1'b0;
    ready_mode  = 0;
    model_depth = 1 << 11;
    clearModel();

    // Single good frame, ramp data, latency and counter timing.
    doReset();
    setReady(1);
    for (int i = 0; i < 64; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t1_frame_count_next_cycle", mon_frame, 1);
    checkOutput("t1_no_early_valid", mon_valid, 0);
    lat = 1;
    while (!mon_valid && lat < 10) begin
      tick();
      lat++;
    end
    checkOutput("t1_latency", lat, 3);
    drainOutput(200);
    checkOutput("t1_beats", beats_seen, 64);
    checkOutput("t1_sof_count", sof_seen, 1);
    checkOutput("t1_eof_count", eof_seen, 1);

    // Good / errored / good.
    doReset();
    setReady(1);
    sendFrame(10, 1'b0, 1'b0);
    sendFrame(20, 1'b0, 1'b1);
    sendFrame(10, 1'b0, 1'b0);
    drainOutput(200);
    checkOutput("t2_beats", beats_seen, 20);
    checkOutput("t2_drop", mon_drop, 1);
    checkOutput("t2_frame", mon_frame, 2);

    // Overflow on the 64-byte instance.
    use_small   = 1'b1;
    model_depth = 64;
    doReset();
    setReady(0);
    sendFrame(70, 1'b0, 1'b0);
    repeat (4) tick();
    checkOutput("t3_ovf_drop", mon_drop, 1);
    checkOutput("t3_ovf_frame", mon_frame, 0);
    checkOutput("t3_ovf_no_valid", mon_valid, 0);
    sendFrame(20, 1'b0, 1'b0);
    lat = 0;
    while (!mon_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("t3_valid_after_commit", mon_valid, 1);
    setReady(1);
    drainOutput(200);
    checkOutput("t3_beats", beats_seen, 20);
    checkOutput("t3_frame", mon_frame, 1);
    checkOutput("t3_drop", mon_drop, 1);
    use_small   = 1'b0;
    model_depth = 1 << 11;

    // Random backpressure on one frame.
    doReset();
    setReady(2);
    sendFrame(16, 1'b0, 1'b0);
    drainOutput(400);
    checkOutput("t4_beats", beats_seen, 16);
    checkOutput("t4_sof_count", sof_seen, 1);
    checkOutput("t4_eof_count", eof_seen, 1);

    // Length FIFO full, then an empty frame.
    doReset();
    setReady(0);
    for (int i = 0; i < 16; i++) sendFrame(1, 1'b0, 1'b0);
    sendFrame(0, 1'b0, 1'b0);
    tick();
    checkOutput("t5_frame", mon_frame, 15);
    checkOutput("t5_drop", mon_drop, 2);
    setReady(1);
    drainOutput(200);
    checkOutput("t5_beats", beats_seen, 15);
    checkOutput("t5_eof_count", eof_seen, 15);

    // Reset in the middle of a frame.
    doReset();
    setReady(1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    reset_n = 1'b0;
    tick();
    checkResetOutputs("t6_in_reset");
    clearModel();
    reset_n = 1'b1;
    tick();
    checkOutput("t6_frame_after_reset", mon_frame, 0);
    sendFrame(8, 1'b0, 1'b0);
    checkOutput("t6_frame_after_commit", mon_frame, 1);
    drainOutput(200);
    checkOutput("t6_beats", beats_seen, 8);
    checkOutput("t6_drop", mon_drop, 0);

    // Random mix of good, errored and empty frames under random backpressure.
    doReset();
    setReady(2);
    for (int f = 0; f < 12; f++) begin
      kind = $urandom_range(0, 9);
      len  = (kind == 2) ? 0 : $urandom_range(1, 40);
      sendFrame(len, 1'b0, kind < 2);
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    end
    drainOutput(2000);
    checkOutput("t7_frame", mon_frame, exp_frames);
    checkOutput("t7_drop", mon_drop, exp_drops);
    checkOutput("t7_eof_count", eof_seen, exp_frames);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
